// File: rtl/otg_hpi_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otg_hpi_sequencer_pkg
//  Description : Shared types and constants for the OTG HPI access sequencer:
//                FSM state encoding, Avalon register offsets, HPI port codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package otg_hpi_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_GAP    = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_GAP    = 3'd6
    } hpi_state_t;

    // Avalon word offsets
    localparam logic [1:0] c_reg_addr = 2'd0;
    localparam logic [1:0] c_reg_data = 2'd1;
    localparam logic [1:0] c_reg_ctrl = 2'd2;

    // HPI port select codes
    localparam logic [1:0] c_hpi_port_data    = 2'd0;
    localparam logic [1:0] c_hpi_port_address = 2'd2;

endpackage
`default_nettype wire

// File: rtl/otg_hpi_sequencer_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hpi_phase_timer
//  Description : 4-bit loadable down-counter timing the HPI strobe and gap
//                phases; saturates at zero and flags it.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpi_phase_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [3:0] i_load_value,
    input  logic       i_count_en,
    output logic       o_zero
);

    logic [3:0] r_count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_count_en && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/otg_hpi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : otg_hpi_sequencer
//  Description : Avalon-MM slave that turns register writes into timed HPI
//                address/data write or read cycles on a 16-bit HPI bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module otg_hpi_sequencer
    import otg_hpi_sequencer_pkg::*;
#(
    parameter int STROBE_CYC = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] c_strobe_load = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_gap_load    = 4'(GAP_CYC - 1);

    hpi_state_t  r_state;
    hpi_state_t  w_next_state;
    logic [15:0] r_target_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_is_write;
    logic        r_done;
    logic        r_overrun;

    logic        w_wr_addr, w_wr_data, w_wr_ctrl, w_go, w_clr;
    logic        w_idle, w_busy, w_start, w_overrun_evt;
    logic        w_zero, w_load, w_finish, w_capture;
    logic [3:0]  w_load_value;
    logic        w_unused;

    assign w_unused = ^writedata[31:16];

    // Avalon write decode
    assign w_wr_addr = chipselect && !write_n && (address == c_reg_addr);
    assign w_wr_data = chipselect && !write_n && (address == c_reg_data);
    assign w_wr_ctrl = chipselect && !write_n && (address == c_reg_ctrl);
    assign w_go      = w_wr_ctrl && writedata[0];
    assign w_clr     = w_wr_ctrl && writedata[1];

    // Busy is judged on the current state, so a start landing on the
    // D_GAP exit edge is rejected as an overrun.
    assign w_idle        = (r_state == IDLE);
    assign w_busy        = !w_idle;
    assign w_start       = w_idle && (w_wr_data || w_go);
    assign w_overrun_evt = w_busy && (w_wr_addr || w_wr_data || w_go);
    assign w_finish      = (r_state == D_GAP) && w_zero;
    assign w_capture     = (r_state == D_STROBE) && w_zero && !r_is_write;

    // Next-state selection and phase-counter reload value.
    always_comb begin
        w_next_state = r_state;
        w_load_value = 4'd0;
        case (r_state)
            IDLE:     if (w_start) w_next_state = A_SETUP;
            A_SETUP:  w_next_state = A_STROBE;
            A_STROBE: if (w_zero) w_next_state = A_GAP;
            A_GAP:    if (w_zero) w_next_state = D_SETUP;
            D_SETUP:  w_next_state = D_STROBE;
            D_STROBE: if (w_zero) w_next_state = D_GAP;
            D_GAP:    if (w_zero) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
        case (w_next_state)
            A_STROBE, D_STROBE: w_load_value = c_strobe_load;
            A_GAP, D_GAP:       w_load_value = c_gap_load;
            default:            w_load_value = 4'd0;
        endcase
    end

    assign w_load = (w_next_state != r_state);

    hpi_phase_timer u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_count_en   (1'b1),
        .o_zero       (w_zero)
    );

    // Sequencer FSM: state, register file, status flags and HPI pins decoded
    // from the next state so every pin is a clean flop output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_target_addr <= 16'd0;
            r_wdata       <= 16'd0;
            r_rdata       <= 16'd0;
            r_is_write    <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            hpi_cs_n      <= 1'b1;
            hpi_rd_n      <= 1'b1;
            hpi_wr_n      <= 1'b1;
            hpi_data_oe   <= 1'b0;
            hpi_addr      <= 2'd0;
            hpi_data_out  <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_idle && w_wr_addr) r_target_addr <= writedata[15:0];
            if (w_idle && w_wr_data) r_wdata <= writedata[15:0];
            if (w_start) r_is_write <= w_wr_data;
            if (w_capture) r_rdata <= hpi_data_in;

            // Completion beats a same-cycle clear; a new start clears done.
            if (w_finish) r_done <= 1'b1;
            else if (w_start || w_clr) r_done <= 1'b0;

            if (w_overrun_evt) r_overrun <= 1'b1;
            else if (w_clr) r_overrun <= 1'b0;

            hpi_cs_n    <= 1'b1;
            hpi_rd_n    <= 1'b1;
            hpi_wr_n    <= 1'b1;
            hpi_data_oe <= 1'b0;
            case (w_next_state)
                A_SETUP, A_STROBE: begin
                    hpi_cs_n     <= 1'b0;
                    hpi_addr     <= c_hpi_port_address;
                    hpi_data_out <= r_target_addr;
                    hpi_data_oe  <= 1'b1;
                    hpi_wr_n     <= (w_next_state != A_STROBE);
                end
                D_SETUP, D_STROBE: begin
                    hpi_cs_n <= 1'b0;
                    hpi_addr <= c_hpi_port_data;
                    if (r_is_write) begin
                        hpi_data_out <= r_wdata;
                        hpi_data_oe  <= 1'b1;
                        hpi_wr_n     <= (w_next_state != D_STROBE);
                    end else begin
                        hpi_rd_n <= (w_next_state != D_STROBE);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered Avalon read mux, one-cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else if (chipselect && write_n) begin
            case (address)
                c_reg_addr: readdata <= {16'd0, r_target_addr};
                c_reg_data: readdata <= {16'd0, r_rdata};
                c_reg_ctrl: readdata <= {29'd0, r_overrun, r_done, w_busy};
                default:    readdata <= 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otg_hpi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otg_hpi_sequencer
//  Description : Scoreboard bench for otg_hpi_sequencer: Avalon reads and HPI
//                accesses are queued as expectations and popped by monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otg_hpi_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // Instance A: default timing
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in = 16'd0;
    logic        hpi_cs_n, hpi_rd_n, hpi_wr_n;

    // Instance B: shortest timing
    logic [1:0]  address_b = 2'd0;
    logic        chipselect_b = 1'b0;
    logic        write_n_b = 1'b1;
    logic [31:0] writedata_b = 32'd0;
    logic [31:0] readdata_b;
    logic [1:0]  hpi_addr_b;
    logic [15:0] hpi_data_out_b;
    logic        hpi_data_oe_b;
    logic        hpi_cs_n_b, hpi_rd_n_b, hpi_wr_n_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otg_hpi_sequencer u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_data_in(hpi_data_in), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
        .hpi_wr_n(hpi_wr_n)
    );

    otg_hpi_sequencer #(.STROBE_CYC(1), .GAP_CYC(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address_b), .chipselect(chipselect_b),
        .write_n(write_n_b), .writedata(writedata_b), .readdata(readdata_b),
        .hpi_addr(hpi_addr_b), .hpi_data_out(hpi_data_out_b), .hpi_data_oe(hpi_data_oe_b),
        .hpi_data_in(16'h0F0F), .hpi_cs_n(hpi_cs_n_b), .hpi_rd_n(hpi_rd_n_b),
        .hpi_wr_n(hpi_wr_n_b)
    );

    typedef struct {
        bit          is_rd;
        logic [1:0]  port;
        logic [15:0] data;
        int          len;
    } hpi_acc_t;

    hpi_acc_t    hpi_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic prot_check(input string tag, input logic rd_n, input logic wr_n,
                              input logic oe, input logic cs_n);
        checks++;
        if ((!rd_n && !wr_n) || (oe && !rd_n) || (cs_n && (!rd_n || !wr_n))) begin
            errors++;
            $display("FAIL protocol_%s: actual rd_n=%b wr_n=%b oe=%b cs_n=%b required legal strobe combination",
                     tag, rd_n, wr_n, oe, cs_n);
        end
    endtask

    task automatic push_hpi(input bit is_rd, input logic [1:0] port, input logic [15:0] data,
                            input int len);
        hpi_acc_t a;
        a.is_rd = is_rd;
        a.port  = port;
        a.data  = data;
        a.len   = len;
        hpi_q.push_back(a);
    endtask

    // Avalon helpers: called on a negedge, return on the next negedge.
    task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_a(input logic [1:0] a, input logic [31:0] exp, input string name);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
        chipselect_b = 1'b1; write_n_b = 1'b0; address_b = a; writedata_b = d;
        @(negedge clk);
        chipselect_b = 1'b0; write_n_b = 1'b1;
    endtask

    task automatic rd_b(input logic [1:0] a, input logic [31:0] exp, input string name);
        chipselect_b = 1'b1; write_n_b = 1'b1; address_b = a;
        @(negedge clk);
        chipselect_b = 1'b0;
        check(name, readdata_b, exp);
    endtask

    // Avalon read monitor for instance A
    bit rd_pend = 1'b0;
    always @(posedge clk) rd_pend = reset_n && chipselect && write_n;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: actual=0x%08h required no read", readdata);
            end else begin
                check(rd_name_q.pop_front(), readdata, rd_exp_q.pop_front());
            end
        end
    end

    // HPI bus monitor for instance A: measures each strobe pulse
    bit          in_pulse = 1'b0;
    bit          cur_is_rd = 1'b0;
    logic [1:0]  cur_port = 2'd0;
    logic [15:0] cur_data = 16'd0;
    int          cur_len = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_pulse = 1'b0;
        end else if (!hpi_wr_n || !hpi_rd_n) begin
            if (!in_pulse) begin
                in_pulse  = 1'b1;
                cur_is_rd = !hpi_rd_n;
                cur_port  = hpi_addr;
                cur_data  = hpi_data_out;
                cur_len   = 0;
            end
            cur_len++;
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            if (hpi_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hpi_unexpected: actual port=%0d len=%0d required none", cur_port, cur_len);
            end else begin
                hpi_acc_t e;
                e = hpi_q.pop_front();
                check("hpi_kind", 32'(cur_is_rd), 32'(e.is_rd));
                check("hpi_port", 32'(cur_port), 32'(e.port));
                check("hpi_len", 32'(cur_len), 32'(e.len));
                if (!e.is_rd) check("hpi_data", 32'(cur_data), 32'(e.data));
            end
        end
    end

    // Protocol checker on both instances
    always @(negedge clk) begin
        if (reset_n) begin
            prot_check("a", hpi_rd_n, hpi_wr_n, hpi_data_oe, hpi_cs_n);
            prot_check("b", hpi_rd_n_b, hpi_wr_n_b, hpi_data_oe_b, hpi_cs_n_b);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_cs_n", 32'(hpi_cs_n), 32'd1);
        check("reset_rd_n", 32'(hpi_rd_n), 32'd1);
        check("reset_wr_n", 32'(hpi_wr_n), 32'd1);
        check("reset_oe", 32'(hpi_data_oe), 32'd0);
        check("reset_hpi_data", 32'(hpi_data_out), 32'd0);
        check("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        rd_a(2'd0, 32'h0, "reset_addr_reg");
        rd_a(2'd2, 32'h0, "reset_status");

        // Write transaction: address then data, 14 cycles
        push_hpi(1'b0, 2'd2, 16'h1234, 4);
        push_hpi(1'b0, 2'd0, 16'hBEEF, 4);
        wr_a(2'd0, 32'hFFFF_1234);
        wr_a(2'd1, 32'h0000_BEEF);
        repeat (13) @(negedge clk);
        rd_a(2'd2, 32'h1, "wr_busy_cycle13");
        rd_a(2'd2, 32'h2, "wr_done_cycle14");
        rd_a(2'd0, 32'h1234, "wr_target_addr");

        // Read transaction
        hpi_data_in = 16'hA5A5;
        push_hpi(1'b0, 2'd2, 16'h0400, 4);
        push_hpi(1'b1, 2'd0, 16'h0000, 4);
        wr_a(2'd0, 32'h0000_0400);
        wr_a(2'd2, 32'h1);
        repeat (14) @(negedge clk);
        rd_a(2'd1, 32'hA5A5, "rd_rdata");
        rd_a(2'd2, 32'h2, "rd_status");
        rd_a(2'd0, 32'h0400, "rd_target_addr");
        rd_a(2'd3, 32'h0, "reserved_reg");

        // Overrun: DATA write during a READ
        hpi_data_in = 16'h5A5A;
        push_hpi(1'b0, 2'd2, 16'h0400, 4);
        push_hpi(1'b1, 2'd0, 16'h0000, 4);
        wr_a(2'd2, 32'h1);
        wr_a(2'd1, 32'h1111);
        rd_a(2'd2, 32'h5, "ovr_status_busy");
        repeat (12) @(negedge clk);
        rd_a(2'd2, 32'h6, "ovr_status_done");
        rd_a(2'd1, 32'h5A5A, "ovr_rdata");
        wr_a(2'd2, 32'h2);
        rd_a(2'd2, 32'h0, "ovr_status_cleared");

        // Reset during D_STROBE of a write
        push_hpi(1'b0, 2'd2, 16'h0400, 4);
        wr_a(2'd1, 32'h2222);
        repeat (9) @(negedge clk);
        check("rst_wr_n_before", 32'(hpi_wr_n), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_cs_n", 32'(hpi_cs_n), 32'd1);
        check("rst_async_wr_n", 32'(hpi_wr_n), 32'd1);
        check("rst_async_oe", 32'(hpi_data_oe), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_a(2'd2, 32'h0, "rst_status");
        rd_a(2'd0, 32'h0, "rst_target_addr");

        // Minimum timing instance: 6-cycle transaction
        wr_b(2'd1, 32'h3333);
        repeat (5) @(negedge clk);
        rd_b(2'd2, 32'h1, "min_busy_cycle5");
        rd_b(2'd2, 32'h2, "min_done_cycle6");
        // Start landing on the completion edge
        wr_b(2'd1, 32'h4444);
        repeat (5) @(negedge clk);
        wr_b(2'd1, 32'h5555);
        rd_b(2'd2, 32'h6, "min_late_start_overrun");
        rd_b(2'd2, 32'h6, "min_late_start_idle");

        repeat (3) @(negedge clk);
        check("hpi_queue_empty", 32'(hpi_q.size()), 32'd0);
        check("read_queue_empty", 32'(rd_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
